aes_cop_ctrl: RTL

- Responder side of the custom-0 (opcode 7'b0001011) decode stall handshake.
- While a custom-0 instruction sits in decode, the hazard logic stalls until aes_done is high. This block accepts that instruction, executes it and pulses aes_done for exactly one cycle to release decode.
- It buffers a 128-bit key and a 128-bit data block, loaded one 32-bit word at a time. It sequences an external AES round engine and returns result words for writeback.

---
 rtl/aes_cop_pkg.sv | 35 +++
 rtl/aes_cop_ctrl_if.sv | 35 +++
 rtl/aes_cop_buf.sv | 37 +++
 rtl/aes_cop_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/aes_cop_pkg.sv
// Shared constants and types for the custom-0 AES coprocessor controller.
// Holds the opcode, funct3 sub-operation codes, FSM state encoding and buffer write types.
package aes_cop_pkg;

  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

  localparam logic [2:0] F_LDKEY = 3'b000;
  localparam logic [2:0] F_LDDAT = 3'b001;
  localparam logic [2:0] F_ENC   = 3'b010;
  localparam logic [2:0] F_DEC   = 3'b011;
  localparam logic [2:0] F_RDRES = 3'b100;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  typedef enum logic {
    BUF_KEY = 1'b0,
    BUF_DAT = 1'b1
  } buf_sel_e;

  typedef struct packed {
    logic        en;
    buf_sel_e    sel;
    logic [1:0]  idx;
    logic [31:0] data;
  } buf_wr_t;

  function automatic logic is_eng_op(input logic [2:0] f3);
    return (f3 == F_ENC) || (f3 == F_DEC);
  endfunction

endpackage

// File: rtl/aes_cop_ctrl_if.sv
// Decode-stage and AES-engine signals of the coprocessor, bundled for port connection.
// slave = the coprocessor controller, master = core pipeline plus round engine.
interface aes_cop_ctrl_if;

  logic [6:0]   op_code;
  logic [2:0]   funct3;
  logic [4:0]   rd;
  logic [31:0]  rs1_data;
  logic [31:0]  rs2_data;
  logic         kill;

  logic         eng_start;
  logic         eng_mode;
  logic [127:0] eng_key;
  logic [127:0] eng_din;
  logic [127:0] eng_dout;
  logic         eng_done;

  logic         aes_done;
  logic [31:0]  rd_data;
  logic         rd_we;
  logic         busy;
  logic         aes_err;

  modport slave (
    input  op_code, funct3, rd, rs1_data, rs2_data, kill, eng_dout, eng_done,
    output eng_start, eng_mode, eng_key, eng_din, aes_done, rd_data, rd_we, busy, aes_err
  );

  modport master (
    output op_code, funct3, rd, rs1_data, rs2_data, kill, eng_dout, eng_done,
    input  eng_start, eng_mode, eng_key, eng_din, aes_done, rd_data, rd_we, busy, aes_err
  );

endinterface

// File: rtl/aes_cop_buf.sv
// Key, data and result buffers, each four 32-bit words with word 0 in bits [31:0].
// Key/data take single-word writes; the result loads all 128 bits at once and reads per word.
module aes_cop_buf
  import aes_cop_pkg::*;
(
  input  logic          clk,
  input  logic          nrst,
  input  buf_wr_t       wr_i,
  input  logic          res_ld_i,
  input  logic [127:0]  res_data_i,
  input  logic [1:0]    rd_idx_i,
  output logic [31:0]   rd_word_o,
  output logic [127:0]  key_o,
  output logic [127:0]  din_o
);

  logic [3:0][31:0] key_q;
  logic [3:0][31:0] dat_q;
  logic [3:0][31:0] res_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      key_q <= '0;
      dat_q <= '0;
      res_q <= '0;
    end else begin
      if (wr_i.en && (wr_i.sel == BUF_KEY)) key_q[wr_i.idx] <= wr_i.data;
      if (wr_i.en && (wr_i.sel == BUF_DAT)) dat_q[wr_i.idx] <= wr_i.data;
      if (res_ld_i) res_q <= res_data_i;
    end
  end

  assign rd_word_o = res_q[rd_idx_i];
  assign key_o     = key_q;
  assign din_o     = dat_q;

endmodule

// File: rtl/aes_cop_ctrl.sv
// Custom-0 AES coprocessor controller: accepts a stalled decode instruction, runs it and
// pulses aes_done for one cycle to release decode.
//
//   state | meaning
//   IDLE  | waiting for a custom-0 request; single-cycle ops execute here
//   START | one-cycle engine start pulse
//   WAIT  | waiting for eng_done with timeout
//   DRAIN | instruction flushed; waiting for the engine to finish, result discarded
//   DONE  | aes_done (and rd_we for RDRES) high for one cycle
module aes_cop_ctrl
  import aes_cop_pkg::*;
#(
  parameter  int TIMEOUT = 64,
  localparam int CNT_W   = $clog2(TIMEOUT) + 1
) (
  input logic           clk,
  input logic           nrst,
  aes_cop_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             err_q, err_d;
  logic             rd_we_q, rd_we_d;
  logic [31:0]      rd_data_q, rd_data_d;

  logic             req;
  logic             tmo;
  logic [1:0]       widx;
  buf_wr_t          buf_wr;
  logic             res_ld;
  logic [31:0]      res_word;
  logic [127:0]     key_vec;
  logic [127:0]     din_vec;
  logic             unused_rs2;

  assign req        = (bus.op_code == OPC_CUSTOM0) && !bus.kill;
  assign widx       = bus.rs2_data[1:0];
  assign unused_rs2 = ^bus.rs2_data[31:2];
  // >= rather than == so a drain entered late can never count past the limit
  assign tmo        = (cnt_q >= CNT_LAST);

  aes_cop_buf u_buf (
    .clk        (clk),
    .nrst       (nrst),
    .wr_i       (buf_wr),
    .res_ld_i   (res_ld),
    .res_data_i (bus.eng_dout),
    .rd_idx_i   (widx),
    .rd_word_o  (res_word),
    .key_o      (key_vec),
    .din_o      (din_vec)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    err_d       = err_q;
    rd_we_d     = 1'b0;
    rd_data_d   = rd_data_q;
    res_ld      = 1'b0;
    buf_wr.en   = 1'b0;
    buf_wr.sel  = BUF_KEY;
    buf_wr.idx  = widx;
    buf_wr.data = bus.rs1_data;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (is_eng_op(bus.funct3)) begin
            mode_d  = bus.funct3[0];
            err_d   = 1'b0;
            cnt_d   = '0;
            state_d = START;
          end else begin
            state_d = DONE;
            case (bus.funct3)
              F_LDKEY: begin
                buf_wr.en  = 1'b1;
                buf_wr.sel = BUF_KEY;
              end
              F_LDDAT: begin
                buf_wr.en  = 1'b1;
                buf_wr.sel = BUF_DAT;
              end
              F_RDRES: begin
                rd_data_d = res_word;
                rd_we_d   = (bus.rd != 5'd0);
              end
              default: ;
            endcase
          end
        end
      end

      START: state_d = bus.kill ? DRAIN : WAIT;

      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.kill) begin
          // engine already finished (or given up on): nothing left to drain
          state_d = (bus.eng_done || tmo) ? IDLE : DRAIN;
        end else if (bus.eng_done) begin
          res_ld  = 1'b1;
          state_d = DONE;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end

      DRAIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.eng_done || tmo) state_d = IDLE;
      end

      DONE:    state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_we_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      err_q     <= err_d;
      rd_we_q   <= rd_we_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.eng_start = (state_q == START);
  assign bus.aes_done  = (state_q == DONE);
  assign bus.busy      = (state_q == START) || (state_q == WAIT) || (state_q == DRAIN);
  assign bus.eng_mode  = mode_q;
  assign bus.aes_err   = err_q;
  assign bus.rd_we     = rd_we_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.eng_key   = key_vec;
  assign bus.eng_din   = din_vec;

endmodule
